// File: rtl/dmem_port_arbiter.sv
// Shares the data RAM's single read/write port between the MEM stage (priority)
// and the debug unit, which is granted when the CPU idles or after a bounded wait.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_spo
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] CNT_MAX = SW'(STARVE_MAX);

    typedef enum logic {ARB, DBG} state_t;

    state_t            r_state, w_next;
    logic [SW-1:0]     r_starve;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;

    logic              w_cpu_active;
    logic              w_pending;
    logic              w_grant;
    logic              w_we;

    assign w_cpu_active = cpu_read | cpu_write;
    // A request seen in its own ack cycle is stale and must not be granted or counted.
    assign w_pending    = dbg_req & ~r_ack;
    assign w_grant      = (r_state == ARB) & w_pending & (~w_cpu_active | (r_starve == CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ARB;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ram_a     = cpu_addr[ADDR_W+1:2];
        ram_d     = cpu_wdata;
        w_we      = cpu_write & ~cpu_read;
        cpu_stall = 1'b0;
        case (r_state)
            ARB: if (w_grant) w_next = DBG;
            DBG: begin
                w_next    = ARB;
                ram_a     = r_addr_q;
                ram_d     = r_wdata_q;
                w_we      = r_we_q;
                cpu_stall = w_cpu_active;
            end
            default: w_next = ARB;
        endcase
    end

    // Write enable is gated by reset so an aborted debug write never lands.
    assign ram_we    = w_we & rst_n;
    assign cpu_rdata = ram_spo;
    assign dbg_ack   = r_ack;
    assign dbg_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve  <= '0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else begin
            r_ack <= (r_state == DBG);
            if (r_state == DBG && !r_we_q)
                r_rdata <= ram_spo;
            if (w_grant) begin
                r_we_q    <= dbg_we;
                r_addr_q  <= dbg_addr;
                r_wdata_q <= dbg_wdata;
            end
            if (w_grant || !dbg_req)
                r_starve <= '0;
            else if (r_state == ARB && w_pending && w_cpu_active && r_starve != CNT_MAX)
                r_starve <= r_starve + SW'(1);
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 256-word RAM
// (asynchronous read, write on rising edge).
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_d, ram_spo;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ram_spo = mem[ram_a];
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

    dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 32'h10;
        cpu_wdata = 32'hBAD0BAD0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick(); tick();
        #1;
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_ack", {31'b0, dbg_ack}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_mem_untouched", mem[4], 32'd0);
        rst_n = 1'b1; cpu_write = 1'b0;

        // CPU write then read, with high/low address bits that must be ignored
        tick();
        cpu_write = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEADBEEF; #1;
        chk("cpu_wr_we", {31'b0, ram_we}, 32'd1);
        chk("cpu_wr_a", {24'b0, ram_a}, 32'd4);
        chk("cpu_wr_d", ram_d, 32'hDEADBEEF);
        chk("cpu_wr_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 32'hFFFF_FC13; #1;
        chk("cpu_rd_a", {24'b0, ram_a}, 32'd4);
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_rd_we", {31'b0, ram_we}, 32'd0);

        // debug read with CPU idle: DBG at t+1, ack at t+2
        tick();
        cpu_read = 1'b0; cpu_addr = 32'h50;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd4; #1;
        chk("dr_t_ack", {31'b0, dbg_ack}, 32'd0);
        chk("dr_t_a", {24'b0, ram_a}, 32'd20);
        tick(); #1;
        chk("dr_t1_a", {24'b0, ram_a}, 32'd4);
        chk("dr_t1_we", {31'b0, ram_we}, 32'd0);
        chk("dr_t1_ack", {31'b0, dbg_ack}, 32'd0);
        tick();
        dbg_req = 1'b0; #1;
        chk("dr_t2_ack", {31'b0, dbg_ack}, 32'd1);
        chk("dr_t2_rdata", dbg_rdata, 32'hDEADBEEF);
        tick(); #1;
        chk("dr_t3_ack", {31'b0, dbg_ack}, 32'd0);
        chk("dr_t3_rdata_held", dbg_rdata, 32'hDEADBEEF);

        // debug write while CPU loads every cycle from the same word: forced grant at t+5
        cpu_read = 1'b1; cpu_addr = 32'h24;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd9; dbg_wdata = 32'h12345678;
        for (int k = 0; k <= 6; k++) begin
            #1;
            chk($sformatf("dw_stall_%0d", k), {31'b0, cpu_stall}, {31'b0, k == 5});
            if (k < 5) chk($sformatf("dw_old_%0d", k), cpu_rdata, 32'h0);
            if (k == 5) begin
                chk("dw_we", {31'b0, ram_we}, 32'd1);
                chk("dw_a", {24'b0, ram_a}, 32'd9);
                chk("dw_d", ram_d, 32'h12345678);
            end
            if (k == 6) begin
                chk("dw_ack", {31'b0, dbg_ack}, 32'd1);
                chk("dw_new", cpu_rdata, 32'h12345678);
                chk("dw_rdata_kept", dbg_rdata, 32'hDEADBEEF);
            end
            tick();
            if (k == 5) dbg_req = 1'b0;
        end
        #1;
        chk("dw_after_ack", {31'b0, dbg_ack}, 32'd0);
        chk("dw_after_stall", {31'b0, cpu_stall}, 32'd0);

        // read + write together: no write issued
        cpu_write = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA5555; #1;
        chk("rw_both_we", {31'b0, ram_we}, 32'd0);
        tick();
        cpu_write = 1'b0; #1;
        chk("rw_both_nowrite", cpu_rdata, 32'h0);

        // request re-presented in the ack cycle is not granted there
        tick();
        cpu_read = 1'b0; cpu_addr = 32'h50;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd9;
        tick();
        tick();
        dbg_addr = 8'd4; #1;
        chk("rp_ack", {31'b0, dbg_ack}, 32'd1);
        chk("rp_rdata", dbg_rdata, 32'h12345678);
        tick(); #1;
        chk("rp_nogrant_a", {24'b0, ram_a}, 32'd20);
        chk("rp_nogrant_ack", {31'b0, dbg_ack}, 32'd0);
        tick(); #1;
        chk("rp_grant_a", {24'b0, ram_a}, 32'd4);
        tick();
        dbg_req = 1'b0; #1;
        chk("rp2_ack", {31'b0, dbg_ack}, 32'd1);
        chk("rp2_rdata", dbg_rdata, 32'hDEADBEEF);

        // reset in the DBG cycle of a debug write
        tick();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd4; dbg_wdata = 32'h55555555;
        tick(); #1;
        chk("ra_dbg_we", {31'b0, ram_we}, 32'd1);
        rst_n = 1'b0; #1;
        chk("ra_we_drop", {31'b0, ram_we}, 32'd0);
        tick();
        rst_n = 1'b1; dbg_req = 1'b0; cpu_read = 1'b1; cpu_addr = 32'h10; #1;
        chk("ra_ack", {31'b0, dbg_ack}, 32'd0);
        chk("ra_rdata_clr", dbg_rdata, 32'd0);
        chk("ra_stall", {31'b0, cpu_stall}, 32'd0);
        chk("ra_arb_a", {24'b0, ram_a}, 32'd4);
        chk("ra_mem_kept", cpu_rdata, 32'hDEADBEEF);
        tick(); #1;
        chk("ra_ack_later", {31'b0, dbg_ack}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
